// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between the instruction fetch unit,
// the load/store buffer, the byte-wide RAM port and the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if;
  logic        if_signal;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        lsb_signal;
  logic        lsb_wr;
  logic        lsb_signed;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_dout;
  logic        lsb_done;
  logic [31:0] lsb_din;

  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  modport slave (
    input  if_signal, if_addr, lsb_signal, lsb_wr, lsb_signed, lsb_len,
           lsb_addr, lsb_dout, mem_din,
    output if_done, if_data, lsb_done, lsb_din, mem_a, mem_wr, mem_dout
  );

  modport master (
    output if_signal, if_addr, lsb_signal, lsb_wr, lsb_signed, lsb_len,
           lsb_addr, lsb_dout, mem_din,
    input  if_done, if_data, lsb_done, lsb_din, mem_a, mem_wr, mem_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM/IO port between instruction
// fetch and the load/store buffer. One requester is served at a time; each
// transfer is sequenced one byte per cycle, reads are assembled little-endian
// and sign/zero extended, and speculative reads are dropped on clear_signal.
// Optional feature macro MEM_ARBITER_RR_EN: when defined, ties are broken
// round-robin; otherwise the load/store buffer always wins a tie.
module mem_arbiter #(
  parameter logic [31:0] IO_ADDR_LO = 32'h30000,
  parameter logic [31:0] IO_ADDR_HI = 32'h30004
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear_signal,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state_r, state_n;
  logic [2:0]  cnt_r, cnt_n;
  logic [2:0]  nbytes_r, nbytes_n;
  logic [31:0] base_r, base_n;
  logic        owner_if_r, owner_if_n;
  logic        ld_signed_r, ld_signed_n;
  logic [1:0]  ld_len_r, ld_len_n;
  logic [31:0] buf_r, buf_n;
  logic [31:0] mem_a_r, mem_a_n;
  logic        mem_wr_r, mem_wr_n;
  logic [7:0]  mem_dout_r, mem_dout_n;
  logic        if_done_r, if_done_n;
  logic [31:0] if_data_r, if_data_n;
  logic        lsb_done_r, lsb_done_n;
  logic [31:0] lsb_din_r, lsb_din_n;
`ifdef MEM_ARBITER_RR_EN
  logic        rr_lsb_r, rr_lsb_n;
`endif

  logic [2:0]  lsb_nbytes;
  logic        io_stall;
  logic        lsb_req;
  logic        if_req;
  logic        can_grant;
  logic        grant_lsb;
  logic        grant_if;
  logic [31:0] rd_word;
  logic [31:0] ld_ext;
  logic [7:0]  st_byte;

  assign bus.if_done  = if_done_r;
  assign bus.if_data  = if_data_r;
  assign bus.lsb_done = lsb_done_r;
  assign bus.lsb_din  = lsb_din_r;
  assign bus.mem_a    = mem_a_r;
  assign bus.mem_wr   = mem_wr_r;
  assign bus.mem_dout = mem_dout_r;

  // Qualify both requests and pick a winner; a flush only lets stores through
  // and nothing is granted while a done pulse is still visible.
  always_comb begin
    case (bus.lsb_len)
      2'b00:   lsb_nbytes = 3'd1;
      2'b01:   lsb_nbytes = 3'd2;
      default: lsb_nbytes = 3'd4;
    endcase
    io_stall  = bus.lsb_wr && io_buffer_full &&
                (bus.lsb_addr >= IO_ADDR_LO) && (bus.lsb_addr <= IO_ADDR_HI);
    lsb_req   = bus.lsb_signal && !io_stall && !(clear_signal && !bus.lsb_wr);
    if_req    = bus.if_signal && !clear_signal;
    can_grant = (state_r == IDLE) && !if_done_r && !lsb_done_r;
`ifdef MEM_ARBITER_RR_EN
    grant_lsb = can_grant && lsb_req && (!if_req || rr_lsb_r);
`else
    grant_lsb = can_grant && lsb_req;
`endif
    grant_if  = can_grant && if_req && !grant_lsb;
  end

  // Byte lane helpers: merge the incoming read byte, extend a finished load,
  // and select the store byte for the current counter value.
  always_comb begin
    rd_word = buf_r;
    case (cnt_r)
      3'd1:    rd_word[7:0]   = bus.mem_din;
      3'd2:    rd_word[15:8]  = bus.mem_din;
      3'd3:    rd_word[23:16] = bus.mem_din;
      3'd4:    rd_word[31:24] = bus.mem_din;
      default: rd_word = buf_r;
    endcase
    case (ld_len_r)
      2'b00:   ld_ext = {{24{ld_signed_r & rd_word[7]}}, rd_word[7:0]};
      2'b01:   ld_ext = {{16{ld_signed_r & rd_word[15]}}, rd_word[15:0]};
      default: ld_ext = rd_word;
    endcase
    case (cnt_r[1:0])
      2'd0:    st_byte = buf_r[7:0];
      2'd1:    st_byte = buf_r[15:8];
      2'd2:    st_byte = buf_r[23:16];
      default: st_byte = buf_r[31:24];
    endcase
  end

  // Next-state and next-output logic for the IDLE/READ/WRITE sequencer.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    nbytes_n    = nbytes_r;
    base_n      = base_r;
    owner_if_n  = owner_if_r;
    ld_signed_n = ld_signed_r;
    ld_len_n    = ld_len_r;
    buf_n       = buf_r;
    mem_a_n     = mem_a_r;
    mem_wr_n    = mem_wr_r;
    mem_dout_n  = mem_dout_r;
    if_done_n   = 1'b0;
    if_data_n   = if_data_r;
    lsb_done_n  = 1'b0;
    lsb_din_n   = lsb_din_r;
`ifdef MEM_ARBITER_RR_EN
    rr_lsb_n    = rr_lsb_r;
`endif
    case (state_r)
      IDLE: begin
        if (grant_lsb) begin
          state_n     = bus.lsb_wr ? WRITE : READ;
          cnt_n       = 3'd1;
          nbytes_n    = lsb_nbytes;
          base_n      = bus.lsb_addr;
          owner_if_n  = 1'b0;
          ld_signed_n = bus.lsb_signed;
          ld_len_n    = bus.lsb_len;
          buf_n       = bus.lsb_wr ? bus.lsb_dout : 32'h0;
          mem_a_n     = bus.lsb_addr;
          mem_wr_n    = bus.lsb_wr;
          mem_dout_n  = bus.lsb_wr ? bus.lsb_dout[7:0] : 8'h00;
          lsb_done_n  = bus.lsb_wr && (lsb_nbytes == 3'd1);
`ifdef MEM_ARBITER_RR_EN
          rr_lsb_n    = 1'b0;
`endif
        end else if (grant_if) begin
          state_n     = READ;
          cnt_n       = 3'd1;
          nbytes_n    = 3'd4;
          base_n      = bus.if_addr;
          owner_if_n  = 1'b1;
          ld_signed_n = 1'b0;
          ld_len_n    = 2'b11;
          buf_n       = 32'h0;
          mem_a_n     = bus.if_addr;
          mem_wr_n    = 1'b0;
          mem_dout_n  = 8'h00;
`ifdef MEM_ARBITER_RR_EN
          rr_lsb_n    = 1'b1;
`endif
        end
      end
      READ: begin
        if (clear_signal) begin
          state_n  = IDLE;
          cnt_n    = 3'd0;
          mem_a_n  = 32'h0;
          mem_wr_n = 1'b0;
        end else begin
          buf_n = rd_word;
          if (cnt_r == nbytes_r) begin
            state_n  = IDLE;
            cnt_n    = 3'd0;
            mem_a_n  = 32'h0;
            mem_wr_n = 1'b0;
            if (owner_if_r) begin
              if_done_n = 1'b1;
              if_data_n = rd_word;
            end else begin
              lsb_done_n = 1'b1;
              lsb_din_n  = ld_ext;
            end
          end else begin
            mem_a_n = base_r + {29'b0, cnt_r};
            cnt_n   = cnt_r + 3'd1;
          end
        end
      end
      WRITE: begin
        if (cnt_r == nbytes_r) begin
          state_n  = IDLE;
          cnt_n    = 3'd0;
          mem_a_n  = 32'h0;
          mem_wr_n = 1'b0;
        end else begin
          mem_a_n    = base_r + {29'b0, cnt_r};
          mem_dout_n = st_byte;
          cnt_n      = cnt_r + 3'd1;
          lsb_done_n = (cnt_r == nbytes_r - 3'd1);
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = 3'd0;
        mem_a_n  = 32'h0;
        mem_wr_n = 1'b0;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything, including pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      nbytes_r    <= 3'd0;
      base_r      <= 32'h0;
      owner_if_r  <= 1'b0;
      ld_signed_r <= 1'b0;
      ld_len_r    <= 2'b00;
      buf_r       <= 32'h0;
      mem_a_r     <= 32'h0;
      mem_wr_r    <= 1'b0;
      mem_dout_r  <= 8'h00;
      if_done_r   <= 1'b0;
      if_data_r   <= 32'h0;
      lsb_done_r  <= 1'b0;
      lsb_din_r   <= 32'h0;
`ifdef MEM_ARBITER_RR_EN
      rr_lsb_r    <= 1'b1;
`endif
    end else if (rdy_in) begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      nbytes_r    <= nbytes_n;
      base_r      <= base_n;
      owner_if_r  <= owner_if_n;
      ld_signed_r <= ld_signed_n;
      ld_len_r    <= ld_len_n;
      buf_r       <= buf_n;
      mem_a_r     <= mem_a_n;
      mem_wr_r    <= mem_wr_n;
      mem_dout_r  <= mem_dout_n;
      if_done_r   <= if_done_n;
      if_data_r   <= if_data_n;
      lsb_done_r  <= lsb_done_n;
      lsb_din_r   <= lsb_din_n;
`ifdef MEM_ARBITER_RR_EN
      rr_lsb_r    <= rr_lsb_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A small combinational RAM
// model answers reads; every step is checked with an immediate assertion.
module tb_mem_arbiter;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_signal;
  logic io_buffer_full;

  int checks   = 0;
  int failures = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear_signal   (clear_signal),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_in = ~clk_in;

  // Byte-wide RAM contents used by the read tests.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: ram_byte = 8'h13;
      32'h0000_0101: ram_byte = 8'h05;
      32'h0000_0102: ram_byte = 8'h00;
      32'h0000_0103: ram_byte = 8'h00;
      32'h0000_0020: ram_byte = 8'h80;
      32'h0000_0040: ram_byte = 8'h34;
      32'h0000_0041: ram_byte = 8'h92;
      32'hFFFF_FFFF: ram_byte = 8'hAB;
      32'h0000_0000: ram_byte = 8'hCD;
      default:       ram_byte = 8'h00;
    endcase
  endfunction

  assign bus.mem_din = ram_byte(bus.mem_a);

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic sgn, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] dout);
    bus.lsb_signal = 1'b1;
    bus.lsb_wr     = wr;
    bus.lsb_signed = sgn;
    bus.lsb_len    = len;
    bus.lsb_addr   = addr;
    bus.lsb_dout   = dout;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] st_word;
    logic [1:0]  arb_seq [3];
    logic [1:0]  arb_exp [3];
    int          n_ev;

    rst_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; io_buffer_full = 1'b0;
    bus.if_signal = 1'b0; bus.if_addr = 32'h0;
    bus.lsb_signal = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_signed = 1'b0;
    bus.lsb_len = 2'b00; bus.lsb_addr = 32'h0; bus.lsb_dout = 32'h0;

    $display("[TB] reset");
    tick(); tick();
    checkOutput("rst_mem_a", bus.mem_a, 32'h0);
    checkOutput("rst_mem_wr", bus.mem_wr, 32'h0);
    checkOutput("rst_mem_dout", bus.mem_dout, 32'h0);
    checkOutput("rst_if_done", bus.if_done, 32'h0);
    checkOutput("rst_lsb_done", bus.lsb_done, 32'h0);
    rst_in = 1'b1;
    tick();

    $display("[TB] ifetch 0x100");
    bus.if_signal = 1'b1; bus.if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("if_mem_a%0d", k), bus.mem_a, 32'h100 + k);
      checkOutput($sformatf("if_nodone%0d", k), bus.if_done, 32'h0);
    end
    tick();
    checkOutput("if_done", bus.if_done, 32'h1);
    checkOutput("if_data", bus.if_data, 32'h0000_0513);
    checkOutput("if_end_mem_a", bus.mem_a, 32'h0);
    bus.if_signal = 1'b0;
    tick();
    checkOutput("if_done_pulse", bus.if_done, 32'h0);

    $display("[TB] loads");
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h20, 32'h0);
    tick();
    checkOutput("lb_mem_a", bus.mem_a, 32'h20);
    tick();
    checkOutput("lb_done", bus.lsb_done, 32'h1);
    checkOutput("lb_signed", bus.lsb_din, 32'hFFFF_FF80);
    bus.lsb_signal = 1'b0;
    tick();
    checkOutput("lb_pulse", bus.lsb_done, 32'h0);

    applyStimulus(1'b0, 1'b0, 2'b00, 32'h20, 32'h0);
    tick(); tick();
    checkOutput("lbu_done", bus.lsb_done, 32'h1);
    // Hold rdy low during the done cycle: the pulse must stay, not repeat.
    rdy_in = 1'b0; bus.lsb_signal = 1'b0;
    tick(); tick();
    checkOutput("rdy_hold_done", bus.lsb_done, 32'h1);
    checkOutput("lbu_unsigned", bus.lsb_din, 32'h0000_0080);
    rdy_in = 1'b1;
    tick();
    checkOutput("rdy_done_cleared", bus.lsb_done, 32'h0);

    applyStimulus(1'b0, 1'b1, 2'b01, 32'h40, 32'h0);
    tick();
    checkOutput("lh_mem_a0", bus.mem_a, 32'h40);
    tick();
    checkOutput("lh_mem_a1", bus.mem_a, 32'h41);
    tick();
    checkOutput("lh_done", bus.lsb_done, 32'h1);
    checkOutput("lh_signed", bus.lsb_din, 32'hFFFF_9234);
    bus.lsb_signal = 1'b0;
    tick();

    applyStimulus(1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    tick();
    checkOutput("wrap_mem_a0", bus.mem_a, 32'hFFFF_FFFF);
    tick();
    checkOutput("wrap_mem_a1", bus.mem_a, 32'h0);
    tick();
    checkOutput("wrap_done", bus.lsb_done, 32'h1);
    checkOutput("wrap_data", bus.lsb_din, 32'h0000_CDAB);
    bus.lsb_signal = 1'b0;
    tick();

    $display("[TB] rdy hold mid-read");
    bus.if_signal = 1'b1; bus.if_addr = 32'h100;
    tick();
    rdy_in = 1'b0;
    tick(); tick();
    checkOutput("rdy_hold_mem_a", bus.mem_a, 32'h100);
    rdy_in = 1'b1;
    tick();
    checkOutput("rdy_resume_mem_a", bus.mem_a, 32'h101);
    tick(); tick(); tick();
    checkOutput("rdy_if_done", bus.if_done, 32'h1);
    checkOutput("rdy_if_data", bus.if_data, 32'h0000_0513);
    bus.if_signal = 1'b0;
    tick();

    $display("[TB] word store");
    st_word = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 2'b11, 32'h1000, st_word);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("sw_wr%0d", k), bus.mem_wr, 32'h1);
      checkOutput($sformatf("sw_a%0d", k), bus.mem_a, 32'h1000 + k);
      checkOutput($sformatf("sw_d%0d", k), bus.mem_dout, {24'h0, st_word[8*k +: 8]});
      checkOutput($sformatf("sw_done%0d", k), bus.lsb_done, (k == 3) ? 32'h1 : 32'h0);
    end
    bus.lsb_signal = 1'b0;
    tick();
    checkOutput("sw_end_wr", bus.mem_wr, 32'h0);
    checkOutput("sw_end_done", bus.lsb_done, 32'h0);

    applyStimulus(1'b1, 1'b0, 2'b00, 32'h2000, 32'h0000_0055);
    tick();
    checkOutput("sb_wr", bus.mem_wr, 32'h1);
    checkOutput("sb_d", bus.mem_dout, 32'h55);
    checkOutput("sb_done", bus.lsb_done, 32'h1);
    bus.lsb_signal = 1'b0;
    tick();
    checkOutput("sb_end_wr", bus.mem_wr, 32'h0);
    checkOutput("sb_end_done", bus.lsb_done, 32'h0);

    $display("[TB] io stall");
    io_buffer_full = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h30000, 32'h0000_00A5);
    bus.if_signal = 1'b1; bus.if_addr = 32'h100;
    tick();
    checkOutput("io_if_granted", bus.mem_a, 32'h100);
    checkOutput("io_no_wr0", bus.mem_wr, 32'h0);
    tick(); tick(); tick(); tick();
    checkOutput("io_if_done", bus.if_done, 32'h1);
    checkOutput("io_if_data", bus.if_data, 32'h0000_0513);
    bus.if_signal = 1'b0;
    tick();
    checkOutput("io_no_wr1", bus.mem_wr, 32'h0);
    tick();
    checkOutput("io_no_wr2", bus.mem_wr, 32'h0);
    io_buffer_full = 1'b0;
    tick();
    checkOutput("io_grant_wr", bus.mem_wr, 32'h1);
    checkOutput("io_grant_a", bus.mem_a, 32'h30000);
    checkOutput("io_grant_d", bus.mem_dout, 32'hA5);
    checkOutput("io_grant_done", bus.lsb_done, 32'h1);
    bus.lsb_signal = 1'b0;
    tick();

    io_buffer_full = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h30004, 32'h0000_0011);
    tick();
    checkOutput("io_hi_stall", bus.mem_wr, 32'h0);
    bus.lsb_addr = 32'h30005;
    tick();
    checkOutput("io_above_wr", bus.mem_wr, 32'h1);
    checkOutput("io_above_a", bus.mem_a, 32'h30005);
    bus.lsb_signal = 1'b0; io_buffer_full = 1'b0;
    tick();

    $display("[TB] clear");
    bus.if_signal = 1'b1; bus.if_addr = 32'h100;
    tick(); tick();
    checkOutput("clr_if_a1", bus.mem_a, 32'h101);
    clear_signal = 1'b1;
    tick();
    checkOutput("clr_if_abort_a", bus.mem_a, 32'h0);
    checkOutput("clr_if_no_done", bus.if_done, 32'h0);
    tick();
    checkOutput("clr_idle_no_grant", bus.mem_a, 32'h0);
    bus.if_signal = 1'b0; clear_signal = 1'b0;
    tick();
    checkOutput("clr_if_still_no_done", bus.if_done, 32'h0);

    applyStimulus(1'b0, 1'b0, 2'b00, 32'h20, 32'h0);
    tick();
    clear_signal = 1'b1;
    tick();
    checkOutput("clr_last_no_done", bus.lsb_done, 32'h0);
    checkOutput("clr_last_din_kept", bus.lsb_din, 32'h0000_CDAB);
    bus.lsb_signal = 1'b0; clear_signal = 1'b0;
    tick();
    checkOutput("clr_last_later", bus.lsb_done, 32'h0);

    st_word = 32'h0102_0304;
    applyStimulus(1'b1, 1'b0, 2'b11, 32'h1000, st_word);
    tick();
    clear_signal = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      clear_signal = 1'b0;
      checkOutput($sformatf("clr_sw_wr%0d", k), bus.mem_wr, 32'h1);
      checkOutput($sformatf("clr_sw_d%0d", k), bus.mem_dout, {24'h0, st_word[8*k +: 8]});
    end
    checkOutput("clr_sw_done", bus.lsb_done, 32'h1);
    bus.lsb_signal = 1'b0;
    tick();
    checkOutput("clr_sw_end_wr", bus.mem_wr, 32'h0);

    $display("[TB] reset mid-read");
    bus.if_signal = 1'b1; bus.if_addr = 32'h100;
    tick(); tick();
    rst_in = 1'b0;
    tick();
    checkOutput("rstm_mem_a", bus.mem_a, 32'h0);
    checkOutput("rstm_mem_wr", bus.mem_wr, 32'h0);
    checkOutput("rstm_mem_dout", bus.mem_dout, 32'h0);
    checkOutput("rstm_if_data", bus.if_data, 32'h0);
    checkOutput("rstm_lsb_din", bus.lsb_din, 32'h0);
    checkOutput("rstm_dones", {bus.if_done, bus.lsb_done}, 32'h0);
    bus.if_signal = 1'b0;
    rst_in = 1'b1;
    tick();

    $display("[TB] arbitration");
    arb_seq = '{2'd0, 2'd0, 2'd0};
`ifdef MEM_ARBITER_RR_EN
    arb_exp = '{2'd1, 2'd2, 2'd1};
`else
    arb_exp = '{2'd1, 2'd1, 2'd1};
`endif
    n_ev = 0;
    bus.if_signal = 1'b1; bus.if_addr = 32'h100;
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h20, 32'h0);
    for (int c = 0; c < 60 && n_ev < 3; c++) begin
      tick();
      if (bus.lsb_done) begin
        arb_seq[n_ev] = 2'd1;
        n_ev++;
      end else if (bus.if_done) begin
        arb_seq[n_ev] = 2'd2;
        n_ev++;
      end
    end
    bus.if_signal = 1'b0; bus.lsb_signal = 1'b0;
    checkOutput("arb_events", n_ev, 32'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("arb_grant%0d", i), {30'h0, arb_seq[i]}, {30'h0, arb_exp[i]});
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
